// File: rtl/fmps_multi_read_link_pkg.sv
// Shared constants, status codes and parser state encodings for the multi-link FMPS reader.
package fmps_pkg;

  localparam logic [15:0] HEADER_MAGIC_DEFAULT = 16'hB6CF;
  localparam int          INDEX_LSB            = 10;

  typedef enum logic [1:0] {
    STATUS_OK      = 2'd0,
    STATUS_MISSING = 2'd1,
    STATUS_DUP     = 2'd2,
    STATUS_ERR     = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    PS_IDLE = 2'd0,
    PS_DATA = 2'd1,
    PS_DROP = 2'd2
  } parser_state_e;

  // Protocol errors outrank duplicates, which outrank a short count.
  function automatic status_e statusOf(input logic anyErr, input logic dup, input logic missing);
    if (anyErr)  return STATUS_ERR;
    if (dup)     return STATUS_DUP;
    if (missing) return STATUS_MISSING;
    return STATUS_OK;
  endfunction

endpackage

// File: rtl/fmps_multi_read_link_if.sv
// Bundle of per-link Aurora RX stream signals; there is no ready, the receiver must keep up.
interface fmps_multi_read_link_if #(
  parameter int NUM_LINKS = 2
) ();
  logic [NUM_LINKS-1:0]    TVALID;
  logic [NUM_LINKS-1:0]    TLAST;
  logic [32*NUM_LINKS-1:0] TDATA;

  modport master (output TVALID, TLAST, TDATA);
  modport slave  (input  TVALID, TLAST, TDATA);
endinterface

// File: rtl/fmps_multi_read_link_rx_parser.sv
// Per-link FMPS packet parser: header check, payload capture, one-deep holding register with req/ack.
// req rises the cycle after TLAST; a packet finishing while the holding register is still pending is dropped.
module fmps_rx_parser
  import fmps_pkg::*;
#(
  parameter int          INDEX_WIDTH    = 5,
  parameter int          NUM_DATA_WORDS = 1,
  parameter logic [15:0] HEADER_MAGIC   = HEADER_MAGIC_DEFAULT
) (
  input  logic                          auroraClk,
  input  logic                          auroraReset,
  input  logic                          tValid,
  input  logic                          tLast,
  input  logic [31:0]                   tData,
  input  logic                          ack,
  output logic                          req,
  output logic [INDEX_WIDTH-1:0]        reqIndex,
  output logic [32*NUM_DATA_WORDS-1:0]  reqData,
  output logic                          magicErr,
  output logic                          lenErr,
  output logic                          ovrErr
);

  localparam int CNT_W = $clog2(NUM_DATA_WORDS + 1);

  parser_state_e                 state, stateNext;
  logic [CNT_W-1:0]              wordCnt;
  logic [INDEX_WIDTH-1:0]        pktIndex;
  logic [32*NUM_DATA_WORDS-1:0]  shiftReg, assembled;
  logic                          isMagic, full, pending, takeWord, complete;

  assign isMagic = (tData[31:16] == HEADER_MAGIC);
  assign full    = (wordCnt == CNT_W'(NUM_DATA_WORDS));
  assign pending = req && !ack;

  always_ff @(posedge auroraClk) begin
    if (auroraReset) state <= PS_IDLE;
    else             state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      PS_IDLE: if (tValid && !tLast) stateNext = isMagic ? PS_DATA : PS_DROP;
      PS_DATA: begin
        if (tValid) begin
          if (tLast)     stateNext = PS_IDLE;
          else if (full) stateNext = PS_DROP;
        end
      end
      PS_DROP: if (tValid && tLast) stateNext = PS_IDLE;
      default: stateNext = PS_IDLE;
    endcase
  end

  always_comb begin
    takeWord = 1'b0;
    complete = 1'b0;
    magicErr = 1'b0;
    lenErr   = 1'b0;
    ovrErr   = 1'b0;
    case (state)
      PS_IDLE: begin
        if (tValid) begin
          if (!isMagic)  magicErr = 1'b1;
          else if (tLast) lenErr  = 1'b1;   // header with no payload at all
        end
      end
      PS_DATA: begin
        if (tValid) begin
          if (full) begin
            lenErr = 1'b1;
          end else begin
            takeWord = 1'b1;
            if (tLast) begin
              if (wordCnt != CNT_W'(NUM_DATA_WORDS - 1)) lenErr = 1'b1;
              else if (pending)                          ovrErr = 1'b1;
              else                                       complete = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Payload word 0 (first after the header) lands in the low 32 bits.
  always_comb begin
    assembled = shiftReg;
    assembled[32*wordCnt +: 32] = tData;
  end

  always_ff @(posedge auroraClk) begin
    if (auroraReset) begin
      wordCnt  <= '0;
      pktIndex <= '0;
      shiftReg <= '0;
      req      <= 1'b0;
      reqIndex <= '0;
      reqData  <= '0;
    end else begin
      if (state == PS_IDLE && tValid) begin
        wordCnt  <= '0;
        pktIndex <= tData[INDEX_LSB +: INDEX_WIDTH];
      end else if (takeWord) begin
        shiftReg <= assembled;
        wordCnt  <= wordCnt + 1'b1;
      end
      if (complete) begin
        req      <= 1'b1;
        reqIndex <= pktIndex;
        reqData  <= assembled;
      end else if (ack) begin
        req <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fmps_multi_read_link.sv
// Multi-link FMPS reader: per-link parsers, round-robin commit into a 2-bank RAM swapped by FAstrobe.
// One commit per cycle; streams have no back-pressure, status pulses the cycle after FAstrobe.
module fmps_multi_read_link
  import fmps_pkg::*;
#(
  parameter int          NUM_LINKS      = 2,
  parameter int          INDEX_WIDTH    = 5,
  parameter int          NUM_DATA_WORDS = 1,
  parameter logic [15:0] HEADER_MAGIC   = HEADER_MAGIC_DEFAULT
) (
  input  logic                          auroraClk,
  input  logic                          auroraReset,
  input  logic                          FAstrobe,
  input  logic [INDEX_WIDTH:0]          expectedCount,
  fmps_multi_read_link_if.slave         rx,
  output logic                          statusStrobe,
  output logic [1:0]                    statusCode,
  output logic [INDEX_WIDTH:0]          statusCounter,
  output logic [2**INDEX_WIDTH-1:0]     fmpsBitmap,
  output logic [INDEX_WIDTH:0]          fmpsCounter,
  output logic                          allPresent,
  input  logic [INDEX_WIDTH-1:0]        readoutAddress,
  output logic [32*NUM_DATA_WORDS-1:0]  readoutData
);

  localparam int SLOTS     = 2**INDEX_WIDTH;
  localparam int PAYLOAD_W = 32*NUM_DATA_WORDS;
  localparam int LINK_W    = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;

  logic [NUM_LINKS-1:0]    req, ack, magicErr, lenErr, ovrErr;
  logic [INDEX_WIDTH-1:0]  reqIndex [NUM_LINKS];
  logic [PAYLOAD_W-1:0]    reqData  [NUM_LINKS];

  for (genvar k = 0; k < NUM_LINKS; k++) begin : gLink
    fmps_rx_parser #(
      .INDEX_WIDTH    (INDEX_WIDTH),
      .NUM_DATA_WORDS (NUM_DATA_WORDS),
      .HEADER_MAGIC   (HEADER_MAGIC)
    ) uParser (
      .auroraClk   (auroraClk),
      .auroraReset (auroraReset),
      .tValid      (rx.TVALID[k]),
      .tLast       (rx.TLAST[k]),
      .tData       (rx.TDATA[32*k +: 32]),
      .ack         (ack[k]),
      .req         (req[k]),
      .reqIndex    (reqIndex[k]),
      .reqData     (reqData[k]),
      .magicErr    (magicErr[k]),
      .lenErr      (lenErr[k]),
      .ovrErr      (ovrErr[k])
    );
  end

  logic [LINK_W-1:0] rrPtr, grantIdx;
  logic              grantVld;

  // Search starts just after the last-granted link so no link can starve.
  always_comb begin
    logic [LINK_W-1:0] cand;
    grantVld = 1'b0;
    grantIdx = rrPtr;
    cand     = rrPtr;
    for (int i = 1; i <= NUM_LINKS; i++) begin
      cand = LINK_W'((int'(rrPtr) + i) % NUM_LINKS);
      if (!grantVld && req[cand]) begin
        grantVld = 1'b1;
        grantIdx = cand;
      end
    end
  end

  always_comb begin
    ack = '0;
    if (grantVld) ack[grantIdx] = 1'b1;
  end

  logic                    activeBank, writeBank, commit, isDup, newErr;
  logic [1:0][SLOTS-1:0]   bitmap;
  logic [SLOTS-1:0]        liveBits, slotBit;
  logic [INDEX_WIDTH-1:0]  gIndex;
  logic [PAYLOAD_W-1:0]    gData;
  logic                    errFlag, dupFlag;
  logic [PAYLOAD_W-1:0]    mem [2*SLOTS];

  // On FAstrobe the grant already targets the freshly cleared bank.
  assign writeBank = FAstrobe ? ~activeBank : activeBank;
  assign liveBits  = FAstrobe ? '0 : bitmap[writeBank];
  assign gIndex    = reqIndex[grantIdx];
  assign gData     = reqData[grantIdx];
  assign slotBit   = SLOTS'(1) << gIndex;
  assign commit    = grantVld && !liveBits[gIndex];
  assign isDup     = grantVld &&  liveBits[gIndex];
  assign newErr    = |{magicErr, lenErr, ovrErr};

  assign fmpsBitmap = bitmap[~activeBank];
  assign allPresent = (fmpsCounter >= expectedCount);

  always_ff @(posedge auroraClk) begin
    if (auroraReset) begin
      activeBank    <= 1'b0;
      bitmap        <= '0;
      fmpsCounter   <= '0;
      rrPtr         <= '0;
      errFlag       <= 1'b0;
      dupFlag       <= 1'b0;
      statusStrobe  <= 1'b0;
      statusCode    <= STATUS_OK;
      statusCounter <= '0;
    end else begin
      if (grantVld) rrPtr <= grantIdx;
      bitmap[writeBank] <= liveBits | (commit ? slotBit : '0);
      fmpsCounter       <= (FAstrobe ? '0 : fmpsCounter) + (INDEX_WIDTH+1)'(commit);
      if (FAstrobe) begin
        activeBank    <= ~activeBank;
        statusStrobe  <= 1'b1;
        statusCounter <= fmpsCounter;
        statusCode    <= statusOf(errFlag, dupFlag, fmpsCounter < expectedCount);
        errFlag       <= newErr;
        dupFlag       <= isDup;
      end else begin
        statusStrobe <= 1'b0;
        errFlag      <= errFlag | newErr;
        dupFlag      <= dupFlag | isDup;
      end
    end
  end

  always_ff @(posedge auroraClk) begin
    if (commit && !auroraReset) mem[{writeBank, gIndex}] <= gData;
  end

  always_ff @(posedge auroraClk) begin
    if (auroraReset) readoutData <= '0;
    else             readoutData <= mem[{~activeBank, readoutAddress}];
  end

endmodule
